// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl
//   Sequences raw PS/2 scan-code bytes into make/break key events. Tracks the
//   0xE0 (extended) and 0xF0 (break) prefixes, maps 16 piano keys to note
//   indices and keeps a bitmap of held notes. A prefix left waiting for more
//   than TIMEOUT_CYCLES clocks is abandoned with a seq_error pulse.
//
//   Optional build macro: TYPEMATIC_FILTER_EN -- when defined, a mapped make
//   for a note that is already held (keyboard auto-repeat) is swallowed.
//
// Ports
//   CLOCK_50     in   1   system clock
//   reset        in   1   synchronous reset, active-high
//   rx_data      in   8   received scan-code byte
//   rx_valid     in   1   strobe, rx_data valid this cycle
//   event_code   out  8   scan code of completed sequence, prefixes stripped
//   event_ext    out  1   sequence contained 0xE0
//   event_break  out  1   sequence contained 0xF0
//   event_valid  out  1   strobe, event_* valid this cycle
//   note_idx     out  4   note index of the last mapped event
//   note_hit     out  1   strobe on make of a mapped piano key
//   held_mask    out 16   bit n set while note n is held
//   seq_error    out  1   strobe on malformed sequence or prefix timeout
module ps2_key_event_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned TMR_W          = 16
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  event_code,
  output logic        event_ext,
  output logic        event_break,
  output logic        event_valid,
  output logic [3:0]  note_idx,
  output logic        note_hit,
  output logic [15:0] held_mask,
  output logic        seq_error
);

  typedef enum logic [1:0] {
    IDLE,
    GOT_E0,
    GOT_F0,
    GOT_E0F0
  } state_t;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [7:0]         event_code_q, event_code_d;
  logic               event_ext_q, event_ext_d;
  logic               event_break_q, event_break_d;
  logic               event_valid_q, event_valid_d;
  logic [3:0]         note_idx_q, note_idx_d;
  logic               note_hit_q, note_hit_d;
  logic [15:0]        held_q, held_d;
  logic               seq_error_q, seq_error_d;

  // Per-cycle sequence outcome from the FSM
  logic is_e0, is_f0, is_ign, timeout;
  logic seq_done, seq_ext, seq_brk, seq_err;

  // {mapped, note index}
  function automatic logic [4:0] map_key(input logic [7:0] code);
    case (code)
      8'h1C:   map_key = {1'b1, 4'd0};
      8'h1D:   map_key = {1'b1, 4'd1};
      8'h1B:   map_key = {1'b1, 4'd2};
      8'h24:   map_key = {1'b1, 4'd3};
      8'h23:   map_key = {1'b1, 4'd4};
      8'h2B:   map_key = {1'b1, 4'd5};
      8'h2C:   map_key = {1'b1, 4'd6};
      8'h34:   map_key = {1'b1, 4'd7};
      8'h35:   map_key = {1'b1, 4'd8};
      8'h33:   map_key = {1'b1, 4'd9};
      8'h3C:   map_key = {1'b1, 4'd10};
      8'h3B:   map_key = {1'b1, 4'd11};
      8'h42:   map_key = {1'b1, 4'd12};
      8'h44:   map_key = {1'b1, 4'd13};
      8'h4B:   map_key = {1'b1, 4'd14};
      8'h4D:   map_key = {1'b1, 4'd15};
      default: map_key = 5'b0;
    endcase
  endfunction

  assign is_e0 = (rx_data == PFX_EXT);
  assign is_f0 = (rx_data == PFX_BRK);

  // Keyboard status/ack bytes, dropped only when no prefix is pending
  always_comb begin
    case (rx_data)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_ign = 1'b1;
      default:                                  is_ign = 1'b0;
    endcase
  end

  // A byte arriving on the timeout cycle takes priority over the timeout
  assign timeout = (state_q != IDLE) && !rx_valid &&
                   (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

  // State register and all registered outputs
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      event_code_q  <= '0;
      event_ext_q   <= 1'b0;
      event_break_q <= 1'b0;
      event_valid_q <= 1'b0;
      note_idx_q    <= '0;
      note_hit_q    <= 1'b0;
      held_q        <= '0;
      seq_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      event_code_q  <= event_code_d;
      event_ext_q   <= event_ext_d;
      event_break_q <= event_break_d;
      event_valid_q <= event_valid_d;
      note_idx_q    <= note_idx_d;
      note_hit_q    <= note_hit_d;
      held_q        <= held_d;
      seq_error_q   <= seq_error_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    seq_done = 1'b0;
    seq_ext  = 1'b0;
    seq_brk  = 1'b0;
    seq_err  = 1'b0;

    if (rx_valid || state_q == IDLE || timeout) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end

    if (rx_valid) begin
      case (state_q)
        IDLE: begin
          if (is_e0)        state_d  = GOT_E0;
          else if (is_f0)   state_d  = GOT_F0;
          else if (!is_ign) seq_done = 1'b1;
        end
        GOT_E0: begin
          if (is_f0) begin
            state_d = GOT_E0F0;
          end else if (is_e0) begin
            seq_err = 1'b1;
          end else begin
            seq_done = 1'b1;
            seq_ext  = 1'b1;
            state_d  = IDLE;
          end
        end
        GOT_F0: begin
          state_d = IDLE;
          if (is_e0 || is_f0) begin
            seq_err = 1'b1;
          end else begin
            seq_done = 1'b1;
            seq_brk  = 1'b1;
          end
        end
        GOT_E0F0: begin
          state_d = IDLE;
          if (is_e0 || is_f0) begin
            seq_err = 1'b1;
          end else begin
            seq_done = 1'b1;
            seq_ext  = 1'b1;
            seq_brk  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (timeout) begin
      state_d = IDLE;
      seq_err = 1'b1;
    end
  end

  // Output logic
  logic [4:0] key;
  logic       mapped;
  logic       suppress;

  always_comb begin
    key           = map_key(rx_data);
    mapped        = key[4] && !seq_ext;
    event_code_d  = event_code_q;
    event_ext_d   = event_ext_q;
    event_break_d = event_break_q;
    note_idx_d    = note_idx_q;
    held_d        = held_q;
    event_valid_d = 1'b0;
    note_hit_d    = 1'b0;
    seq_error_d   = seq_err;

`ifdef TYPEMATIC_FILTER_EN
    suppress = mapped && !seq_brk && held_q[key[3:0]];
`else
    suppress = 1'b0;
`endif

    if (seq_done && !suppress) begin
      event_valid_d = 1'b1;
      event_code_d  = rx_data;
      event_ext_d   = seq_ext;
      event_break_d = seq_brk;
      if (mapped) begin
        note_idx_d = key[3:0];
        if (seq_brk) begin
          held_d[key[3:0]] = 1'b0;
        end else begin
          held_d[key[3:0]] = 1'b1;
          note_hit_d       = 1'b1;
        end
      end
    end
  end

  assign event_code  = event_code_q;
  assign event_ext   = event_ext_q;
  assign event_break = event_break_q;
  assign event_valid = event_valid_q;
  assign note_idx    = note_idx_q;
  assign note_hit    = note_hit_q;
  assign held_mask   = held_q;
  assign seq_error   = seq_error_q;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Scoreboard bench for ps2_key_event_ctrl. The driver runs a reference model
// of the scan-code rules and queues expected outputs tagged with the clock
// on which they must appear; a negedge monitor pops and compares them.
module tb_ps2_key_event_ctrl;

  localparam int unsigned TO = 300;

`ifdef TYPEMATIC_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b1;
  logic [7:0]  rx_data  = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  event_code;
  logic        event_ext, event_break, event_valid;
  logic [3:0]  note_idx;
  logic        note_hit;
  logic [15:0] held_mask;
  logic        seq_error;

  ps2_key_event_ctrl #(.TIMEOUT_CYCLES(TO), .TMR_W(16)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .event_code (event_code),
    .event_ext  (event_ext),
    .event_break(event_break),
    .event_valid(event_valid),
    .note_idx   (note_idx),
    .note_hit   (note_hit),
    .held_mask  (held_mask),
    .seq_error  (seq_error)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  typedef struct {
    int          edge_no;
    bit          is_err;
    logic [7:0]  code;
    bit          ext;
    bit          brk;
    bit          hit;
    bit          chk_idx;
    logic [3:0]  idx;
    logic [15:0] held;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
    end
  endfunction

  // ---------------- reference model ----------------
  logic [7:0] keymap [16] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C, 8'h34,
                              8'h35, 8'h33, 8'h3C, 8'h3B, 8'h42, 8'h44, 8'h4B, 8'h4D};
  logic [7:0] ign_list [6] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

  bit          m_pend, m_e0, m_f0;
  int          m_last;
  logic [15:0] m_held;

  function automatic int note_of(logic [7:0] c);
    for (int i = 0; i < 16; i++) if (keymap[i] == c) return i;
    return -1;
  endfunction

  function automatic bit ignorable(logic [7:0] c);
    for (int i = 0; i < 6; i++) if (ign_list[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void push_err(int e);
    exp_t x;
    x = '{edge_no: e, is_err: 1'b1, code: 8'h00, ext: 1'b0, brk: 1'b0, hit: 1'b0,
          chk_idx: 1'b0, idx: 4'h0, held: 16'h0};
    q.push_back(x);
  endfunction

  function automatic void clear_pfx();
    m_pend = 1'b0; m_e0 = 1'b0; m_f0 = 1'b0;
  endfunction

  // A pending prefix expires TO clocks after the last byte unless a byte lands by then
  function automatic void model_age(int e);
    if (m_pend && (e - m_last) > int'(TO)) begin
      push_err(m_last + int'(TO));
      clear_pfx();
    end
  endfunction

  function automatic void model_byte(logic [7:0] b, int e);
    int   n;
    exp_t x;
    model_age(e);
    m_last = e;
    if (b == 8'hE0) begin
      if (!m_pend) begin m_pend = 1'b1; m_e0 = 1'b1; end
      else if (m_f0) begin push_err(e); clear_pfx(); end
      else push_err(e);
    end else if (b == 8'hF0) begin
      if (!m_pend) begin m_pend = 1'b1; m_f0 = 1'b1; end
      else if (m_f0) begin push_err(e); clear_pfx(); end
      else m_f0 = 1'b1;
    end else if (!m_pend && ignorable(b)) begin
      // dropped
    end else begin
      n = m_e0 ? -1 : note_of(b);
      if (!(FILT && n >= 0 && !m_f0 && m_held[n])) begin
        x = '{edge_no: e, is_err: 1'b0, code: b, ext: m_e0, brk: m_f0, hit: 1'b0,
              chk_idx: (n >= 0), idx: 4'h0, held: 16'h0};
        if (n >= 0) begin
          x.idx = 4'(n);
          if (m_f0) m_held[n] = 1'b0;
          else begin m_held[n] = 1'b1; x.hit = 1'b1; end
        end
        x.held = m_held;
        q.push_back(x);
      end
      clear_pfx();
    end
  endfunction

  // ---------------- driver ----------------
  task automatic send(input logic [7:0] b, input int gap);
    model_byte(b, cyc + gap + 1);
    repeat (gap) begin @(posedge CLOCK_50); #1; end
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge CLOCK_50); #1;
    rx_valid = 1'b0;
    rx_data  = $urandom_range(0, 255);
  endtask

  task automatic idle(input int n);
    model_age(cyc + n + 1);
    repeat (n) begin @(posedge CLOCK_50); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge CLOCK_50); #1;
    reset = 1'b0;
    clear_pfx();
    m_held = '0;
  endtask

  // ---------------- monitor ----------------
  exp_t cur;
  always @(negedge CLOCK_50) begin
    while (q.size() > 0 && q[0].edge_no < cyc) begin
      cur = q.pop_front();
      errors++; checks++;
      $display("FAIL missing_output due cycle %0d: got none expected %s", cur.edge_no,
               cur.is_err ? "seq_error" : "event");
    end
    if (event_valid && seq_error) begin
      errors++; checks++;
      $display("FAIL exclusive at cycle %0d: got event_valid=1 seq_error=1 expected not both", cyc);
    end
    if (event_valid || seq_error || note_hit) begin
      if (q.size() == 0 || q[0].edge_no != cyc) begin
        errors++; checks++;
        $display("FAIL unexpected_output at cycle %0d: got ev=%0b err=%0b hit=%0b expected none",
                 cyc, event_valid, seq_error, note_hit);
      end else begin
        cur = q.pop_front();
        chk("seq_error", {31'b0, seq_error}, {31'b0, cur.is_err});
        chk("event_valid", {31'b0, event_valid}, {31'b0, !cur.is_err});
        if (!cur.is_err) begin
          chk("event_code", {24'b0, event_code}, {24'b0, cur.code});
          chk("event_ext", {31'b0, event_ext}, {31'b0, cur.ext});
          chk("event_break", {31'b0, event_break}, {31'b0, cur.brk});
          chk("note_hit", {31'b0, note_hit}, {31'b0, cur.hit});
          chk("held_mask", {16'b0, held_mask}, {16'b0, cur.held});
          if (cur.chk_idx) chk("note_idx", {28'b0, note_idx}, {28'b0, cur.idx});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 99);
    if (r < 12) return 8'hE0;
    if (r < 27) return 8'hF0;
    if (r < 67) return keymap[$urandom_range(0, 15)];
    if (r < 75) return ign_list[$urandom_range(0, 5)];
    return 8'($urandom_range(0, 255));
  endfunction

  function automatic int rand_gap();
    int r;
    r = $urandom_range(0, 99);
    if (r < 80) return $urandom_range(0, 2);
    if (r < 96) return $urandom_range(3, 10);
    return $urandom_range(TO - 2, TO + 1);
  endfunction

  initial begin
    clear_pfx();
    m_held = '0;
    m_last = 0;
    #1;
    repeat (2) begin @(posedge CLOCK_50); #1; end
    do_reset();

    chk("rst_event_valid", {31'b0, event_valid}, 32'd0);
    chk("rst_seq_error", {31'b0, seq_error}, 32'd0);
    chk("rst_note_hit", {31'b0, note_hit}, 32'd0);
    chk("rst_held_mask", {16'b0, held_mask}, 32'd0);
    chk("rst_event_code", {24'b0, event_code}, 32'd0);
    chk("rst_ext_brk", {30'b0, event_ext, event_break}, 32'd0);
    chk("rst_note_idx", {28'b0, note_idx}, 32'd0);

    // make / break of note 0
    send(8'h1C, 1);
    send(8'hF0, 1); send(8'h1C, 0);
    // extended make / break, held untouched
    send(8'hE0, 1); send(8'h75, 0);
    send(8'hE0, 1); send(8'hF0, 0); send(8'h75, 2);
    // prefix timeout, then a clean make of note 1
    send(8'hF0, 1); idle(TO + 5);
    send(8'h1D, 0);
    // auto-repeat of note 0
    send(8'h1C, 1); send(8'h1C, 0); send(8'h1C, 3);
    chk("repeat_held", {16'b0, held_mask}, {16'b0, m_held});
    send(8'hF0, 1); send(8'h1C, 0);
    send(8'hF0, 0); send(8'h1D, 0);
    // malformed and ignored sequences
    send(8'hF0, 1); send(8'hF0, 0);
    send(8'hAA, 1);
    send(8'hE0, 1); send(8'hE0, 0); send(8'h74, 0);
    // byte arriving exactly on the timeout cycle wins; one cycle later loses
    send(8'hF0, 1); send(8'h23, TO - 1);
    send(8'hF0, 1); send(8'h23, TO);
    send(8'hF0, 0); send(8'h23, 0);
    // reset discards a pending prefix
    send(8'hE0, 1);
    do_reset();
    send(8'h2B, 0);
    idle(2);
    chk("post_reset_held", {16'b0, held_mask}, 32'h0020);

    for (int i = 0; i < 400; i++) send(rand_byte(), rand_gap());

    idle(TO + 5);
    chk("final_held_mask", {16'b0, held_mask}, {16'b0, m_held});
    chk("queue_drained", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog at cycle %0d: got no finish expected finish", cyc);
    $fatal(1);
  end

endmodule
